// File: rtl/alu_seq_pkg.sv
// Shared encodings for the multi-cycle ALU sequencer: op codes, ALU control
// words and FSM states.
package alu_seq_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CTL_W = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_SHL  = 2'b10,
    OP_SHR  = 2'b11
  } op_e;

  // ALU control word {ex,nx,ey,ny,f,no}
  localparam logic [CTL_W-1:0] ALU_ADD  = 6'b101010;
  localparam logic [CTL_W-1:0] ALU_SUB  = 6'b101110;
  localparam logic [CTL_W-1:0] ALU_ZERO = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_ctr.sv
// Iteration down-counter; holds the remaining count minus one and flags zero
// one cycle ahead so the last iteration is known from registered state.
module alu_seq_ctr
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle MUL / DIVU / SHL / SHR sequencer that borrows the CPU's
// combinational ALU for one operation per clock.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     result_lo,
  output logic [W-1:0]     result_hi,
  output logic             div0,
  output logic [W-1:0]     alu_x,
  output logic [W-1:0]     alu_y,
  output logic [CTL_W-1:0] alu_c,
  output logic             alu_cin,
  output logic             alu_en,
  input  logic [W-1:0]     alu_val,
  input  logic             alu_cflag
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [W-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic              div0_q, div0_d;
  logic              busy_q, done_q;
  logic [W-1:0]      x_q, x_d, y_q, y_d;
  logic [CTL_W-1:0]  c_q, c_d;
  logic              cin_q, cin_d;
  logic              ctr_load, ctr_dec, ctr_zero;
  logic [CNT_W-1:0]  ctr_load_val;
  logic [W-1:0]      r_shift, q_shift;

  alu_seq_ctr u_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  // Next state, working registers, and the ALU drive for the coming cycle
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    div0_d       = div0_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_dec      = 1'b0;
    x_d          = '0;
    y_d          = '0;
    c_d          = ALU_ZERO;
    cin_d        = 1'b0;
    r_shift      = {hi_q[W-2:0], lo_q[W-1]};
    q_shift      = {lo_q[W-2:0], 1'b0};

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          op_d     = op_e'(op);
          a_d      = a;
          b_d      = b;
          div0_d   = 1'b0;
          ctr_load = 1'b1;
          case (op_d)
            OP_MUL: begin
              hi_d         = '0;
              lo_d         = b;
              ctr_load_val = CNT_W'(15);
              state_d      = ST_RUN;
            end
            OP_DIVU: begin
              if (b == '0) begin
                hi_d    = a;
                lo_d    = '1;
                div0_d  = 1'b1;
                state_d = ST_DONE;
              end else begin
                hi_d         = '0;
                lo_d         = a;
                ctr_load_val = CNT_W'(15);
                state_d      = ST_RUN;
              end
            end
            default: begin
              hi_d         = '0;
              lo_d         = a;
              ctr_load_val = b[CNT_W-1:0] - CNT_W'(1);
              state_d      = (b[CNT_W-1:0] == '0) ? ST_DONE : ST_RUN;
            end
          endcase
        end
      end
      ST_RUN: begin
        ctr_dec = 1'b1;
        state_d = ctr_zero ? ST_DONE : ST_RUN;
        case (op_q)
          OP_MUL: begin
            if (lo_q[0]) {hi_d, lo_d} = {alu_cflag, alu_val, lo_q[W-1:1]};
            else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[W-1:1]};
          end
          OP_DIVU: begin
            // hi_q[W-1] is the bit shifted out of R; when set, R' >= b always
            if (alu_cflag || hi_q[W-1]) begin
              hi_d = alu_val;
              lo_d = q_shift | W'(1);
            end else begin
              hi_d = r_shift;
              lo_d = q_shift;
            end
          end
          OP_SHL: begin
            lo_d = alu_val;
            hi_d = {hi_q[W-2:0], alu_cflag};
          end
          default: begin
            lo_d = {1'b0, lo_q[W-1:1]};
            hi_d = '0;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) begin
      case (op_d)
        OP_MUL: begin
          if (lo_d[0]) begin
            x_d = hi_d;
            y_d = a_d;
            c_d = ALU_ADD;
          end
        end
        OP_DIVU: begin
          x_d   = {hi_d[W-2:0], lo_d[W-1]};
          y_d   = b_d;
          c_d   = ALU_SUB;
          cin_d = 1'b1;
        end
        OP_SHL: begin
          x_d = lo_d;
          y_d = lo_d;
          c_d = ALU_ADD;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= ALU_ZERO;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE);
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      cin_q   <= cin_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign div0      = div0_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign alu_c     = c_q;
  assign alu_cin   = cin_q;
  assign alu_en    = 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table plus hand-written multi-cycle
// sequences, with a behavioural model of the CPU ALU closing the loop.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a, b;
  logic        busy, done, div0, alu_cin, alu_en, alu_cflag;
  logic [15:0] result_lo, result_hi, alu_x, alu_y, alu_val;
  logic [5:0]  alu_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .div0      (div0),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_c     (alu_c),
    .alu_cin   (alu_cin),
    .alu_en    (alu_en),
    .alu_val   (alu_val),
    .alu_cflag (alu_cflag)
  );

  // CPU ALU: {ex,nx,ey,ny,f,no}; f=1 adds with carry-in, f=0 ANDs
  logic [15:0] xe, ye;
  logic [16:0] sum;
  always_comb begin
    xe = alu_c[5] ? alu_x : 16'h0;
    if (alu_c[4]) xe = ~xe;
    ye = alu_c[3] ? alu_y : 16'h0;
    if (alu_c[2]) ye = ~ye;
    sum = {1'b0, xe} + {1'b0, ye} + 17'(alu_cin);
    if (alu_c[1]) begin
      alu_val   = sum[15:0];
      alu_cflag = sum[16];
    end else begin
      alu_val   = xe & ye;
      alu_cflag = 1'b0;
    end
    if (alu_c[0]) alu_val = ~alu_val;
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          n;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start at a falling edge; returns edges after the start edge until done is seen
  task automatic do_op(input logic [1:0] o, input logic [15:0] ia, input logic [15:0] ib,
                       output int edges, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, bcnt, dcnt;

    vecs[0]  = '{2'b00, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 16};
    vecs[1]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 16};
    vecs[2]  = '{2'b00, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 1'b0, 16};
    vecs[3]  = '{2'b01, 16'd1000, 16'd7,    16'h008E, 16'h0006, 1'b0, 16};
    vecs[4]  = '{2'b01, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 16};
    vecs[5]  = '{2'b01, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 0};
    vecs[6]  = '{2'b10, 16'h8001, 16'd3,    16'h0008, 16'h0004, 1'b0, 3};
    vecs[7]  = '{2'b11, 16'h8001, 16'd15,   16'h0001, 16'h0000, 1'b0, 15};
    vecs[8]  = '{2'b10, 16'hABCD, 16'd0,    16'hABCD, 16'h0000, 1'b0, 0};
    vecs[9]  = '{2'b01, 16'd7,    16'd1000, 16'h0000, 16'h0007, 1'b0, 16};
    vecs[10] = '{2'b10, 16'hFFFF, 16'd15,   16'h8000, 16'h7FFF, 1'b0, 15};
    vecs[11] = '{2'b11, 16'hF0F0, 16'd4,    16'h0F0F, 16'h0000, 1'b0, 4};
    vecs[12] = '{2'b10, 16'h0001, 16'h00F4, 16'h0010, 16'h0000, 1'b0, 4};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst lo", 32'(result_lo), 32'h0);
    check("rst hi", 32'(result_hi), 32'h0);
    check("rst div0", 32'(div0), 32'h0);
    check("rst alu_c", 32'(alu_c), 32'h02);
    check("rst alu_xy", {alu_x, alu_y}, 32'h0);
    check("rst alu_cin", 32'(alu_cin), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, bcnt);
      check($sformatf("v%0d lo", i), 32'(result_lo), 32'(vecs[i].lo));
      check($sformatf("v%0d hi", i), 32'(result_hi), 32'(vecs[i].hi));
      check($sformatf("v%0d div0", i), 32'(div0), 32'(vecs[i].dz));
      check($sformatf("v%0d latency", i), 32'(edges), 32'(vecs[i].n));
      check($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].n));
      check($sformatf("v%0d busy at done", i), 32'(busy), 32'h0);
      check($sformatf("v%0d alu idle", i), {10'h0, alu_c, alu_x}, {10'h0, 6'b000010, 16'h0});
      check($sformatf("v%0d alu_en", i), 32'(alu_en), 32'h0);
    end

    // Result holds after done, one cycle later still the same
    @(negedge clk);
    check("hold lo", 32'(result_lo), 32'h0010);
    check("done one cycle", 32'(done), 32'h0);

    // Start pulse during busy is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0010;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 16'd5; b = 16'd1;
    @(negedge clk);
    start = 1'b0;
    edges = 4;
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("busy-start latency", 32'(edges), 32'd16);
    check("busy-start result", {result_hi, result_lo}, 32'h0001_2340);

    // Reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'h0);
    check("midrst result", {result_hi, result_lo}, 32'h0);
    check("midrst alu", {10'h0, alu_c, alu_x}, {10'h0, 6'b000010, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst no done", 32'(dcnt), 32'h0);

    // Back-to-back start in the DONE cycle
    do_op(2'b10, 16'h0001, 16'd2, edges, bcnt);
    check("b2b first lo", 32'(result_lo), 32'h0004);
    check("b2b first latency", 32'(edges), 32'd2);
    start = 1'b1; op = 2'b11; a = 16'h0100; b = 16'd4;
    @(negedge clk);
    start = 1'b0;
    check("b2b done drops", 32'(done), 32'h0);
    check("b2b busy", 32'(busy), 32'h1);
    edges = 0;
    while (!done && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("b2b second latency", 32'(edges), 32'd4);
    check("b2b second lo", {result_hi, result_lo}, 32'h0000_0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
